// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: PC/IF/ID/ID/EX sequencing for load-use, branch-operand and slow data-memory hazards.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_rs, id_rt          source registers of the ID instruction, with id_uses_rs/id_uses_rt qualifiers
//   id_is_branch          ID instruction is beq/bne; branch_taken is its comparator result
//   ex_reg_write, ex_mem_read, ex_rd   EX instruction destination info
//   mem_mem_read, mem_rd               MEM instruction destination info
//   dmem_req, dmem_ready               data-memory handshake of the MEM stage
//   pc_write, ifid_write  PC and IF/ID enables
//   ifid_flush            IF/ID cleared to nop at next edge
//   idex_bubble           ID/EX loaded with nop control
//   pipe_freeze           hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout           sticky flag: memory did not answer within MEM_TIMEOUT wait cycles
// Optional (macro HAZARD_PERF_CNT_EN): stall_cycles, flush_count, freeze_cycles saturating counters.
module hazard_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_is_branch,
    input  logic       branch_taken,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       mem_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       pipe_freeze,
    output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] freeze_cycles
`endif
);
    typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} state_t;

    state_t           state;
    logic [1:0]       scnt;
    logic [CNT_W-1:0] wcnt;
    logic             ret_stall;
    logic             ex_hit, mem_hit, need2, need1, mem_stall, frz, stl, fl;

    always_comb begin
        ex_hit    = (id_uses_rs && id_rs != 5'd0 && id_rs == ex_rd) ||
                    (id_uses_rt && id_rt != 5'd0 && id_rt == ex_rd);
        mem_hit   = (id_uses_rs && id_rs != 5'd0 && id_rs == mem_rd) ||
                    (id_uses_rt && id_rt != 5'd0 && id_rt == mem_rd);
        need2     = id_is_branch && ex_hit && ex_mem_read;
        need1     = (ex_hit && ex_mem_read) || (id_is_branch && ex_hit && ex_reg_write) ||
                    (id_is_branch && mem_hit && mem_mem_read);
        mem_stall = dmem_req && !dmem_ready;
        // a pending memory access outranks every hazard, including an in-progress STALL
        frz       = state == MEM_WAIT || mem_stall;
        stl       = !frz && (state == STALL || need1);
        fl        = !frz && !stl && id_is_branch && branch_taken;
        pc_write    = !reset && !frz && !stl;
        ifid_write  = !reset && !frz && !stl;
        ifid_flush  = reset || fl;
        idex_bubble = reset || stl;
        pipe_freeze = !reset && frz;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            scnt        <= 2'd0;
            wcnt        <= '0;
            ret_stall   <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state     <= MEM_WAIT;
                        wcnt      <= CNT_W'(1);
                        ret_stall <= 1'b0;
                    end else if (need2) begin
                        state <= STALL;
                        scnt  <= 2'd1;
                    end
                end
                STALL: begin
                    // preemption keeps scnt so the stall resumes after the wait
                    if (mem_stall) begin
                        state     <= MEM_WAIT;
                        wcnt      <= CNT_W'(1);
                        ret_stall <= 1'b1;
                    end else begin
                        scnt  <= scnt - 2'd1;
                        state <= (scnt == 2'd1) ? RUN : STALL;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= ret_stall ? STALL : RUN;
                        wcnt  <= '0;
                    end else if (wcnt == CNT_W'(MEM_TIMEOUT)) begin
                        mem_timeout <= 1'b1;
                    end else begin
                        wcnt <= wcnt + CNT_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles  <= '0;
            flush_count   <= '0;
            freeze_cycles <= '0;
        end else begin
            if (idex_bubble && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
            if (ifid_flush && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
            if (pipe_freeze && freeze_cycles != '1) freeze_cycles <= freeze_cycles + CNT_W'(1);
        end
    end
`endif
endmodule
